// File: rtl/regfile_scoreboard_rv32.sv
// Parametrised integer register file with a per-register pending-write scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_scoreboard_rv32 #(
    parameter  int unsigned W    = 32,
    parameter  int unsigned NREG = 32,
    parameter  int unsigned NR   = 2,
    localparam int unsigned AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wr_addr,
    input  logic [W-1:0]     wr_data,
    input  logic             claim_valid,
    input  logic [AW-1:0]    claim_addr,
    input  logic [NR*AW-1:0] rs_addr,
    output logic [NR*W-1:0]  rs_data,
    output logic [NR-1:0]    rs_busy,
    output logic [NREG-1:0]  busy_vec,
    output logic             any_busy
);

    logic [W-1:0]    mem_q [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            any_busy_q;
    logic            wr_en;
    logic            claim_en;

    assign wr_en    = we && (wr_addr != '0);
    assign claim_en = claim_valid && (claim_addr != '0);

    // Writeback retires a pending write; a same-edge claim belongs to a newer producer and wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (claim_en) begin
            busy_d[claim_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            any_busy_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
            busy_q     <= busy_d;
            any_busy_q <= |busy_d;
        end
    end

    assign busy_vec = busy_q;
    assign any_busy = any_busy_q;

    // Combinational read ports; x0 and out-of-range addresses read as zero and not busy.
    always_comb begin
        logic [AW-1:0] ra;
        rs_data = '0;
        rs_busy = '0;
        ra      = '0;
        for (int k = 0; k < int'(NR); k++) begin
            ra = rs_addr[k*AW +: AW];
            if ((32'(ra) < NREG) && (ra != '0)) begin
                rs_data[k*W +: W] = mem_q[ra];
                rs_busy[k]        = busy_q[ra];
            end
`ifdef REGFILE_BYPASS_EN
            // Forward writeback data; busy only if a new producer claims the same register now.
            if (!rst && wr_en && (ra == wr_addr)) begin
                rs_data[k*W +: W] = wr_data;
                rs_busy[k]        = claim_en && (claim_addr == wr_addr);
            end
`endif
        end
    end

endmodule

// File: tb/tb_regfile_scoreboard_rv32.sv
// Scoreboard bench for regfile_scoreboard_rv32: a 32x32/2-port and a 16x32/4-port instance.
module tb_regfile_scoreboard_rv32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: NREG=32, NR=2
    logic        we_a, claim_a;
    logic [4:0]  wr_addr_a, claim_addr_a;
    logic [31:0] wr_data_a;
    logic [9:0]  rs_addr_a;
    logic [63:0] rs_data_a;
    logic [1:0]  rs_busy_a;
    logic [31:0] busy_vec_a;
    logic        any_busy_a;

    // Instance B: NREG=16, NR=4
    logic        we_b, claim_b;
    logic [3:0]  wr_addr_b, claim_addr_b;
    logic [31:0] wr_data_b;
    logic [15:0] rs_addr_b;
    logic [127:0] rs_data_b;
    logic [3:0]  rs_busy_b;
    logic [15:0] busy_vec_b;
    logic        any_busy_b;

    regfile_scoreboard_rv32 #(.W(32), .NREG(32), .NR(2)) dut_a (
        .clk(clk), .rst(rst), .we(we_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a),
        .claim_valid(claim_a), .claim_addr(claim_addr_a), .rs_addr(rs_addr_a),
        .rs_data(rs_data_a), .rs_busy(rs_busy_a), .busy_vec(busy_vec_a), .any_busy(any_busy_a)
    );

    regfile_scoreboard_rv32 #(.W(32), .NREG(16), .NR(4)) dut_b (
        .clk(clk), .rst(rst), .we(we_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .claim_valid(claim_b), .claim_addr(claim_addr_b), .rs_addr(rs_addr_b),
        .rs_data(rs_data_b), .rs_busy(rs_busy_b), .busy_vec(busy_vec_b), .any_busy(any_busy_b)
    );

    typedef struct {
        bit          dut_b;
        bit          is_vec;
        int          port;
        logic [31:0] exp_data;
        logic        exp_busy;
        logic [31:0] exp_vec;
        logic        exp_any;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    task automatic exp_port(input bit b, input int p, input logic [31:0] d, input logic bz,
                            input string nm);
        exp_t e;
        e.dut_b = b; e.is_vec = 1'b0; e.port = p; e.exp_data = d; e.exp_busy = bz;
        e.exp_vec = '0; e.exp_any = 1'b0; e.name = nm;
        exp_q.push_back(e);
    endtask

    task automatic exp_vec(input bit b, input logic [31:0] v, input logic an, input string nm);
        exp_t e;
        e.dut_b = b; e.is_vec = 1'b1; e.port = 0; e.exp_data = '0; e.exp_busy = 1'b0;
        e.exp_vec = v; e.exp_any = an; e.name = nm;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every queued expectation against DUT outputs mid-cycle.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] ad, av;
        logic        ab, aa;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (!e.is_vec) begin
                if (e.dut_b) begin
                    ad = rs_data_b[e.port*32 +: 32];
                    ab = rs_busy_b[e.port];
                end else begin
                    ad = rs_data_a[e.port*32 +: 32];
                    ab = rs_busy_a[e.port];
                end
                if (ad !== e.exp_data || ab !== e.exp_busy) begin
                    errors++;
                    $display("FAIL %s: port%0d data=%h busy=%b, expected data=%h busy=%b",
                             e.name, e.port, ad, ab, e.exp_data, e.exp_busy);
                end
            end else begin
                av = e.dut_b ? {16'h0, busy_vec_b} : busy_vec_a;
                aa = e.dut_b ? any_busy_b : any_busy_a;
                if (av !== e.exp_vec || aa !== e.exp_any) begin
                    errors++;
                    $display("FAIL %s: busy_vec=%h any_busy=%b, expected busy_vec=%h any_busy=%b",
                             e.name, av, aa, e.exp_vec, e.exp_any);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        we_a = 1'b0; claim_a = 1'b0;
        we_b = 1'b0; claim_b = 1'b0;
    endtask

    task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
        we_a = 1'b1; wr_addr_a = a; wr_data_a = d;
    endtask

    task automatic cl_a(input logic [4:0] a);
        claim_a = 1'b1; claim_addr_a = a;
    endtask

    task automatic rd_a(input int p, input logic [4:0] a);
        rs_addr_a[p*5 +: 5] = a;
    endtask

    task automatic rd_b(input int p, input logic [3:0] a);
        rs_addr_b[p*4 +: 4] = a;
    endtask

    initial begin
        rst = 1'b1;
        we_a = 1'b0; claim_a = 1'b0; wr_addr_a = '0; wr_data_a = '0; claim_addr_a = '0;
        we_b = 1'b0; claim_b = 1'b0; wr_addr_b = '0; wr_data_b = '0; claim_addr_b = '0;
        rs_addr_a = '0; rs_addr_b = '0;

        // Reset state
        rd_a(0, 5'd1); rd_a(1, 5'd31);
        exp_port(0, 0, 32'h0, 1'b0, "reset_x1");
        exp_port(0, 1, 32'h0, 1'b0, "reset_x31");
        exp_vec(0, 32'h0, 1'b0, "reset_vec");

        cyc(); rst = 1'b0;
        wr_a(5'd5, 32'hDEADBEEF);

        cyc(); rd_a(0, 5'd5); rd_a(1, 5'd0); wr_a(5'd0, 32'h1234);
        exp_port(0, 0, 32'hDEADBEEF, 1'b0, "write_read_x5");
        exp_port(0, 1, 32'h0, 1'b0, "x0_during_write");

        cyc(); rd_a(0, 5'd7); rd_a(1, 5'd0); cl_a(5'd7);
        exp_port(0, 1, 32'h0, 1'b0, "x0_after_write");
        exp_port(0, 0, 32'h0, 1'b0, "x7_before_claim");
        exp_vec(0, 32'h0, 1'b0, "vec_before_claim");

        cyc();
        exp_port(0, 0, 32'h0, 1'b1, "x7_claimed");
        exp_vec(0, 32'h0000_0080, 1'b1, "vec_x7_claimed");

        cyc(); rd_a(0, 5'd5); wr_a(5'd7, 32'hA5);
        exp_vec(0, 32'h0000_0080, 1'b1, "vec_during_wb");

        cyc(); rd_a(0, 5'd7);
        exp_port(0, 0, 32'hA5, 1'b0, "x7_written_back");
        exp_vec(0, 32'h0, 1'b0, "vec_x7_cleared");

        // Claim and write to the same register in one cycle
        cyc(); rd_a(0, 5'd5); cl_a(5'd3); wr_a(5'd3, 32'h55);

        cyc(); rd_a(0, 5'd3); cl_a(5'd0);
        exp_port(0, 0, 32'h55, 1'b1, "collision_x3");
        exp_vec(0, 32'h0000_0008, 1'b1, "collision_vec");

        cyc(); cl_a(5'd10); wr_a(5'd11, 32'h77);
        exp_vec(0, 32'h0000_0008, 1'b1, "claim_x0_ignored");

        cyc(); rd_a(0, 5'd11); rd_a(1, 5'd10); wr_a(5'd3, 32'h66);
        exp_port(0, 0, 32'h77, 1'b0, "diff_write_x11");
        exp_port(0, 1, 32'h0, 1'b1, "diff_claim_x10");
        exp_vec(0, 32'h0000_0408, 1'b1, "diff_vec");

        cyc(); rd_a(0, 5'd3); wr_a(5'd9, 32'h11);
        we_b = 1'b1; wr_addr_b = 4'd1; wr_data_b = 32'hB1;
        exp_port(0, 0, 32'h66, 1'b0, "x3_rewritten");
        exp_vec(0, 32'h0000_0400, 1'b1, "vec_x3_cleared");

        cyc(); rd_a(0, 5'd9); cl_a(5'd9);
        we_b = 1'b1; wr_addr_b = 4'd15; wr_data_b = 32'hBF;
        exp_port(0, 0, 32'h11, 1'b0, "x9_initial");

        // Same-cycle write and read of a busy register
        cyc(); rd_a(0, 5'd9); rd_a(1, 5'd9); wr_a(5'd9, 32'h22);
        claim_b = 1'b1; claim_addr_b = 4'd2;
        exp_port(0, 0, BYP ? 32'h22 : 32'h11, BYP ? 1'b0 : 1'b1, "bypass_x9_p0");
        exp_port(0, 1, BYP ? 32'h22 : 32'h11, BYP ? 1'b0 : 1'b1, "bypass_x9_p1");
        exp_vec(0, 32'h0000_0600, 1'b1, "vec_not_bypassed");

        cyc(); rd_a(0, 5'd9); rd_a(1, 5'd10); wr_a(5'd10, 32'h33); cl_a(5'd10);
        rd_b(0, 4'd1); rd_b(1, 4'd15); rd_b(2, 4'd2); rd_b(3, 4'd0);
        exp_port(0, 0, 32'h22, 1'b0, "x9_after_wb");
        exp_port(0, 1, BYP ? 32'h33 : 32'h0, 1'b1, "bypass_with_claim_x10");
        exp_vec(0, 32'h0000_0400, 1'b1, "vec_after_x9_wb");
        exp_port(1, 0, 32'hB1, 1'b0, "b_x1");
        exp_port(1, 1, 32'hBF, 1'b0, "b_x15");
        exp_port(1, 2, 32'h0, 1'b1, "b_x2_claimed");
        exp_port(1, 3, 32'h0, 1'b0, "b_x0");
        exp_vec(1, 32'h0000_0004, 1'b1, "b_vec");

        cyc(); rd_a(1, 5'd10); wr_a(5'd4, 32'h40);
        exp_port(0, 1, 32'h33, 1'b1, "x10_rewritten_still_busy");
        exp_vec(0, 32'h0000_0400, 1'b1, "vec_x10_busy");

        cyc(); rd_a(0, 5'd4);
        exp_port(0, 0, 32'h40, 1'b0, "x4_before_reset");

        // Asynchronous reset asserted between edges while writes are pending
        cyc(); rd_a(0, 5'd4); rd_a(1, 5'd10); wr_a(5'd4, 32'h44);
        we_b = 1'b1; wr_addr_b = 4'd1; wr_data_b = 32'h99;
        rd_b(3, 4'd1);
        #2 rst = 1'b1;
        exp_port(0, 0, 32'h0, 1'b0, "reset_mid_x4");
        exp_port(0, 1, 32'h0, 1'b0, "reset_mid_x10");
        exp_vec(0, 32'h0, 1'b0, "reset_mid_vec");
        for (int p = 0; p < 4; p++) begin
            exp_port(1, p, 32'h0, 1'b0, "b_reset_mid_port");
        end
        exp_vec(1, 32'h0, 1'b0, "b_reset_mid_vec");

        cyc(); rst = 1'b0; rd_a(0, 5'd4);
        exp_port(0, 0, 32'h0, 1'b0, "x4_write_lost");
        exp_port(1, 3, 32'h0, 1'b0, "b_x1_write_lost");
        exp_vec(0, 32'h0, 1'b0, "vec_after_reset");

        cyc();
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_scoreboard_rv32.md
# regfile_scoreboard_rv32

Parametrised successor to the RV32I integer register file, for the pipelined core: configurable data width, register count (32 for RV32I, 16 for RV32E) and number of read ports. It adds a per-register scoreboard of pending writes, so that issue logic can stall on long-latency producers (loads, future MUL/DIV). An optional same-cycle write-to-read bypass is also provided. It sits between decode/issue (reads, claims) and writeback (writes).

## Interface
- W, 32: data width in bits.
- NREG, 32: number of architectural registers; legal values are 16 or 32.
- NR, 2: number of read ports, 1 to 4.
- AW, $clog2(NREG): register address width; derived, not overridden.

- clk  in  1: clock, rising edge.
- rst  in  1: reset rst, asynchronous, active-high.
- we  in  1: writeback enable.
- wr_addr  in  AW: writeback destination.
- wr_data  in  W: writeback data.
- claim_valid  in  1: marks a register as pending (producer issued).
- claim_addr  in  AW: register being claimed.
- rs_addr  in  NR*AW: packed read addresses; port k is at [k*AW +: AW].
- rs_data  out  NR*W: packed read data; port k is at [k*W +: W].
- rs_busy  out  NR: per-port flag; 1 means the register read on that port has a pending write.
- busy_vec  out  NREG: raw scoreboard, bit i = register i pending.
- any_busy  out  1: OR of busy_vec.

## Operation
- Storage: NREG x W array. Register 0 is hardwired to zero.
  - Reads of register 0 return 0.
  - Writes to register 0 are dropped.
  - busy_vec[0] is always 0.
  - Claims on register 0 are ignored.
- Write: on the rising edge with we=1 and wr_addr!=0, mem[wr_addr] <= wr_data. The same edge clears busy[wr_addr].
- Claim: on the rising edge with claim_valid=1 and claim_addr!=0, busy[claim_addr] <= 1.
- Claim on an already-busy register (WAW) is legal; busy stays 1.
- Simultaneous claim and write to the same register: the claim wins. Data is written and busy ends at 1, because a newer producer owns the register.
- Simultaneous claim and write to different registers: both take effect independently.
- A write to a non-busy register is legal: data is stored and busy stays 0.
- Reads are combinational per port, from the array and scoreboard state. Address bits at or above NREG read as 0 with rs_busy=0; no error is flagged.
- Reset: all registers read 0, busy_vec=0, any_busy=0. Every rs_data therefore reads 0 and every rs_busy reads 0 while rst is asserted.
- Reset asserted mid-operation overrides any same-cycle write or claim. Both are lost.

## Timing
- Read latency: 0 cycles (combinational), from rs_addr to rs_data/rs_busy.
- Write latency: 1 cycle. Data is visible on reads in the cycle after the write edge; with the bypass enabled, it is visible in the same cycle.
- Claim latency: 1 cycle. busy_vec and rs_busy go to 1 in the cycle after the claim edge.
- busy_vec and any_busy are registered state only. They are never bypassed.
- There are no handshakes and no stalls inside the block. The core holds issue while rs_busy is set.

## Configuration
- REGFILE_BYPASS_EN defined:
  - If we=1, wr_addr!=0 and rs_addr[k]==wr_addr in the same cycle, port k returns wr_data.
  - That port's rs_busy is forced to 0, unless claim_valid targets the same register in that cycle; then rs_busy=1.
- REGFILE_BYPASS_EN undefined:
  - Reads return the array contents only, so the old value is seen during a same-cycle write.
  - rs_busy reflects the registered busy bit only.
  - Writeback-to-issue then costs one extra cycle.

## Test plan
- Reset: assert rst with NREG=32, NR=2 and read x1 and x31 → rs_data=0, rs_busy=0, busy_vec=0, any_busy=0.
- Write then read: write 0xDEADBEEF to x5, read x5 next cycle → 0xDEADBEEF. Write 0x1234 to x0, read x0 → 0.
- Scoreboard: claim x7, check the next cycle → busy_vec[7]=1, any_busy=1, and rs_busy=1 on a port reading x7. Write 0xA5 to x7 → next cycle busy=0 and data=0xA5.
- Collision: in one cycle, claim x3 and write 0x55 to x3 → next cycle busy_vec[3]=1 and mem[x3]=0x55. Claim on x0 → busy_vec[0] stays 0.
- Bypass:
  - With REGFILE_BYPASS_EN: x9 is busy and holds 0x11. Write 0x22 to x9 and read x9 in the same cycle → rs_data=0x22, rs_busy=0.
  - Without the macro, same stimulus → rs_data=0x11, rs_busy=1.
- Async reset mid-operation: assert rst between edges while we=1 targets x4 → x4 reads 0 and busy_vec=0. Repeat with NREG=16 and NR=4 → all four ports read 0.
